// File: rtl/rec01_sweep_ctrl_pkg.sv
// Shared types and sizes for the rec01 truth-table sweep controller.
package rec01_sweep_ctrl_pkg;

    localparam int unsigned NUM_COMB = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned HOLD_W   = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/rec01_sweep_ctrl_ex01c.sv
// Combinational function under test: s = (~b & c) | (~a & b & ~c) | (a & b & d).
module rec01_sweep_ctrl_ex01c (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic s
);

    assign s = (~b & c) | (~a & b & ~c) | (a & b & d);

endmodule

// File: rtl/rec01_sweep_ctrl.sv
// Sweeps all 16 input combinations of ex01c and captures its truth table.
// Define SWEEP_CHECK_EN to add an exp_tt input and a registered mismatch flag.
module rec01_sweep_ctrl
    import rec01_sweep_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [NUM_COMB-1:0] tt,
    output logic                tt_valid,
    output logic [IDX_W-1:0]    cur_idx
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [NUM_COMB-1:0] exp_tt,
    output logic                mismatch
`endif
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [NUM_COMB-1:0] tt_q;
    logic                tt_valid_q;
    logic                s;
    logic                last_hold;
    logic                last_idx;
    logic                start_ok;
    logic                sample;

    rec01_sweep_ctrl_ex01c u_ex01c (
        .a (idx_q[3]),
        .b (idx_q[2]),
        .c (idx_q[1]),
        .d (idx_q[0]),
        .s (s)
    );

    assign last_hold = (hold_q == HOLD_W'(HOLD_CYCLES));
    assign last_idx  = (idx_q == IDX_W'(NUM_COMB - 1));
    // abort outranks both a new start and the sample of the current combination
    assign start_ok  = (state_q == StIdle) && start && !abort;
    assign sample    = (state_q == StRun) && last_hold && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StRun;
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last_hold && last_idx) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            hold_q     <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
        end else if (start_ok) begin
            idx_q      <= '0;
            hold_q     <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
        end else if (sample) begin
            tt_q[idx_q] <= s;
            hold_q      <= '0;
            if (last_idx) begin
                tt_valid_q <= 1'b1;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else if ((state_q == StRun) && !abort) begin
            hold_q <= hold_q + HOLD_W'(1);
        end
    end

`ifdef SWEEP_CHECK_EN
    logic [NUM_COMB-1:0] tt_final;
    logic                mismatch_q;

    // Table as it will stand after the final sample lands.
    assign tt_final = tt_q | ({{(NUM_COMB - 1){1'b0}}, s} << idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (start_ok) begin
            mismatch_q <= 1'b0;
        end else if (sample && last_idx) begin
            mismatch_q <= (tt_final != exp_tt);
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;
    assign cur_idx  = idx_q;

endmodule

// File: doc/rec01_sweep_ctrl.md
REC01_SWEEP_CTRL -- requirements
Module: rec01_sweep_ctrl

Interface
REQ-001 HOLD_CYCLES, default 0: extra settle cycles held per input combination before sampling; range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a 16-combination sweep.
REQ-005 abort  input  1  cancels a sweep in progress.
REQ-006 busy  output  1  high while a sweep is running.
REQ-007 done  output  1  one-cycle pulse when a sweep completes.
REQ-008 tt  output  16  captured truth table; bit i = function output for combination i.
REQ-009 tt_valid  output  1  tt holds a complete, unaborted sweep.
REQ-010 cur_idx  output  4  combination currently driven; a=cur_idx[3], b=[2], c=[1], d=[0].

Function
REQ-011 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after sampling idx 15, DONE->IDLE unconditionally next cycle.
REQ-012 Start accepted in IDLE only; start in RUN or DONE ignored, no restart.
REQ-013 On accepted start: idx<=0, hold counter<=0, tt<=0, tt_valid<=0.
REQ-014 In RUN, the function inputs SHALL be driven combinationally from the idx register; busy=1.
REQ-015 Each combination held HOLD_CYCLES+1 cycles; s sampled into tt[idx] on the last hold cycle, then idx increments (4-bit, no wrap used since 15 ends the sweep).
REQ-016 HOLD_CYCLES=0 latency: start at cycle 0, RUN cycles 1..16, done=1 and tt_valid=1 at cycle 17; general RUN length 16*(HOLD_CYCLES+1).
REQ-017 done SHALL be high exactly one cycle (DONE state); tt and tt_valid held until next accepted start.
REQ-018 abort in RUN: next state IDLE, busy=0, no done pulse, tt_valid stays 0, partial tt retained but invalid.
REQ-019 abort and start same cycle in IDLE: abort wins, start ignored; abort in IDLE/DONE has no effect.
REQ-020 abort on the sampling cycle of idx 15: abort wins, no done.
REQ-021 cur_idx SHALL equal idx in all states; idx holds its last value after a sweep.

Reset
REQ-022 rst asserted: state=IDLE, idx=0, hold counter=0, tt=0, tt_valid=0, busy=0, done=0, immediately without a clock edge.
REQ-023 rst mid-sweep SHALL discard the sweep; first start after rst release starts a fresh sweep.

Configuration
REQ-024 Macro SWEEP_CHECK_EN: when defined, adds input exp_tt[15:0] and output mismatch[1]; mismatch registered with done, =1 iff tt!=exp_tt, held until next accepted start, reset 0.
REQ-025 Without SWEEP_CHECK_EN, exp_tt and mismatch ports and comparison logic are absent; all other behaviour identical.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE/RUN/DONE), NUM_COMB=16, IDX_W=4, HOLD_W=4.
REQ-027 One sub-module ex01c instantiated for the function s=(~b&c)|(~a&b&~c)|(a&b&d); controller holds no copy of the equation.

Verification
REQ-028 HOLD_CYCLES=0, start pulse at cycle 0 -> busy cycles 1..16, done at cycle 17, tt=16'hAC3C, tt_valid=1.
REQ-029 HOLD_CYCLES=3, start -> 64 busy cycles, each cur_idx held 4 cycles, tt=16'hAC3C.
REQ-030 start repeated at cycles 5 and 10 during RUN -> ignored; single done at cycle 17, tt=16'hAC3C.
REQ-031 abort at cycle 8 -> busy=0 at cycle 9, no done, tt_valid=0; new start then yields tt=16'hAC3C.
REQ-032 rst asserted asynchronously mid-cycle at cycle 6 -> all outputs 0 before next edge; post-reset sweep correct.
REQ-033 SWEEP_CHECK_EN defined, exp_tt=16'hAC3C -> mismatch=0; exp_tt=16'hAC3D -> mismatch=1 with done.
